cmem_arbiter: RTL
=================

Name: cmem_arbiter

Overview:
- Round-robin arbiter that shares the single layer-memory port (csel / crd / cwr / caddr_rd / caddr_wr / cdata_wr / cdata_rd) among the three CONV engines.
- Requester 0: conv engine, writes L0.
- Requester 1: max-pool engine, reads L0, writes L1.
- Requester 2: flatten engine, reads L1, writes L2.
- Issues at most one memory transaction per cycle and routes read data back to the requester that issued the read.

Parameters:
DATA_W, 20, memory data width
ADDR_W, 12, memory address width
SEL_W, 3, memory select width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0/req1/req2  in  1 each  transaction request; held with its fields until granted
we0/we1/we2  in  1 each  1 = write, 0 = read
sel0/sel1/sel2  in  SEL_W each  target memory: 001 L0_MEM0, 010 L0_MEM1, 011 L1_MEM0, 100 L1_MEM1, 101 L2_MEM
addr0/addr1/addr2  in  ADDR_W each  memory address
wdata0/wdata1/wdata2  in  DATA_W each  write data
gnt0/gnt1/gnt2  out  1 each  combinational grant, same cycle as the accepted request
rdata  out  DATA_W  registered read data, shared by all requesters
rvalid0/rvalid1/rvalid2  out  1 each  rdata valid for that requester
csel  out  SEL_W  registered memory select
crd  out  1  registered read strobe
caddr_rd  out  ADDR_W  registered read address
cwr  out  1  registered write strobe
caddr_wr  out  ADDR_W  registered write address
cdata_wr  out  DATA_W  registered write data
cdata_rd  in  DATA_W  memory read data; valid at the rising edge ending the crd cycle
sel_err  out  1  sticky flag: a request with an illegal select was granted
idle  out  1  1 when no request pending and no read in flight

Behaviour:
- Reset values: gnt*=0, rvalid*=0, rdata=0, csel=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, sel_err=0, idle=1, rr pointer=0.
- Reset is synchronous. If asserted mid-operation it clears everything above and squashes any in-flight read, so no rvalid pulse follows.
- Arbitration:
  - rr pointer ptr ∈ {0,1,2}; priority order is ptr, ptr+1, ptr+2 (mod 3).
  - The first requester with req=1 gets gnt=1 in the same cycle; at most one gnt is high.
  - On a grant to k, ptr <= (k+1) mod 3 at the next edge. With no grant, ptr holds.
  - gnt depends only on req* and ptr (registered) — no combinational path from we/sel/addr/data.
  - Requester handshake: the transaction completes at the edge where req&gnt=1; the requester may present its next transaction the following cycle.
- Issue (edge ending grant cycle T):
  - Register csel=sel_k.
  - If we_k: cwr=1, caddr_wr=addr_k, cdata_wr=wdata_k, crd=0.
  - Else: crd=1, caddr_rd=addr_k, cwr=0.
  - Strobes stay high for exactly cycle T+1 unless cycle T+1 also grants.
  - caddr_rd, caddr_wr and cdata_wr hold their last values when not strobed. csel holds its last value.
- Illegal select (000, 110, 111):
  - The request is still granted, which advances ptr.
  - crd=cwr=0 in T+1, sel_err<=1 (sticky until reset), and no rvalid is produced.
- Read return:
  - A 2-bit id pipeline tracks the owner of a read issued in T+1.
  - At the edge ending T+1: rdata<=cdata_rd and rvalid_owner<=1, high for cycle T+2 only.
  - Read latency is 2 edges from grant. Back-to-back reads give one rvalid per cycle, in grant order.
- Writes produce no response.
- idle = ~(req0|req1|req2) & ~crd & ~rvalid_any (registered-input combinational).
- Full throughput is one grant per cycle. Simultaneous reads and writes from different requesters are serialized by the arbiter; there is no read/write hazard reordering.

Test Plan:
- Reset, then req0 write sel=001 addr=0x005 wdata=0x0ABCD -> gnt0 same cycle; next cycle cwr=1, csel=001, caddr_wr=0x005, cdata_wr=0x0ABCD; crd=0; idle returns to 1.
- req1 read sel=001 addr=0x010, memory model returns 0x12345 -> crd=1, caddr_rd=0x010 at T+1; rvalid1=1, rdata=0x12345 at T+2; rvalid0=rvalid2=0.
- req0..2 held high for 6 cycles from ptr=0 -> grant sequence 0,1,2,0,1,2; exactly one gnt per cycle; 6 memory strobes.
- req2 read sel=011 addr=0x3FF back-to-back with req1 read sel=100 addr=0x000 -> two consecutive crd cycles; rvalid2 then rvalid1 on consecutive cycles with the correct data.
- req1 with sel=110 -> gnt1=1; crd=cwr=0 next cycle; sel_err=1 and stays 1; no rvalid; next legal request served normally.
- Read granted, reset asserted the cycle crd=1 -> the following cycle rvalid*=0, crd=0, sel_err=0, ptr=0.

Source files
------------

// File: rtl/cmem_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port among the conv,
// max-pool and flatten engines; routes registered read data back to its owner.
module cmem_arbiter #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              we0,
    input  logic              we1,
    input  logic              we2,
    input  logic [SEL_W-1:0]  sel0,
    input  logic [SEL_W-1:0]  sel1,
    input  logic [SEL_W-1:0]  sel2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic              gnt0,
    output logic              gnt1,
    output logic              gnt2,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic [SEL_W-1:0]  csel,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              sel_err,
    output logic              idle
);

    localparam int NREQ = 3;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    mreq_t [NREQ-1:0] rq;
    logic  [NREQ-1:0] req_v;
    logic  [NREQ-1:0] gnt;
    logic  [NREQ-1:0] rvalid;
    logic  [1:0]      ptr;
    logic  [1:0]      gidx;
    logic  [1:0]      rd_owner;
    mreq_t            g;
    logic             g_any;
    logic             sel_ok;

    assign req_v = {req2, req1, req0};
    assign rq[0] = {we0, sel0, addr0, wdata0};
    assign rq[1] = {we1, sel1, addr1, wdata1};
    assign rq[2] = {we2, sel2, addr2, wdata2};

    // Grant depends only on req and the registered pointer.
    always_comb begin
        int kk;
        gnt  = '0;
        gidx = '0;
        kk   = 0;
        for (int i = 0; i < NREQ; i++) begin
            kk = int'(ptr) + i;
            if (kk >= NREQ) kk = kk - NREQ;
            if (!(|gnt) && req_v[kk]) begin
                gnt[kk] = 1'b1;
                gidx    = 2'(kk);
            end
        end
    end

    assign g_any  = |gnt;
    assign g      = rq[gidx];
    assign sel_ok = (g.sel >= SEL_W'(1)) && (g.sel <= SEL_W'(5));

    assign {gnt2, gnt1, gnt0}          = gnt;
    assign {rvalid2, rvalid1, rvalid0} = rvalid;
    assign idle = ~(|req_v) & ~crd & ~(|rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            rd_owner <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            csel     <= '0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            sel_err  <= 1'b0;
        end else begin
            crd    <= 1'b0;
            cwr    <= 1'b0;
            rvalid <= '0;
            // Read issued last cycle: memory data is valid at this edge.
            if (crd) begin
                rdata            <= cdata_rd;
                rvalid[rd_owner] <= 1'b1;
            end
            if (g_any) begin
                ptr  <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                csel <= g.sel;
                if (sel_ok) begin
                    if (g.we) begin
                        cwr      <= 1'b1;
                        caddr_wr <= g.addr;
                        cdata_wr <= g.wdata;
                    end else begin
                        crd      <= 1'b1;
                        caddr_rd <= g.addr;
                        rd_owner <= gidx;
                    end
                end else begin
                    // Illegal target: consume the grant but touch no memory.
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule
